// File: rtl/traffic_interval_timer.sv
// Interval timer for the traffic-light sequencer: stores base/extended/yellow
// durations and counts them down on 1 Hz ticks, pulsing expired at zero.
module traffic_interval_timer #(
  parameter int WIDTH    = 4,
  parameter int DEF_BASE = 6,
  parameter int DEF_EXT  = 3,
  parameter int DEF_YEL  = 2
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             one_hz_enable,
  input  logic             start_timer,
  input  logic [1:0]       interval,
  input  logic             Prog_Sync,
  input  logic [1:0]       Time_Parameter_Selector,
  input  logic [WIDTH-1:0] Time_Value,
  output logic             expired,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] ext;
  logic [WIDTH-1:0] yel;

  function automatic logic [WIDTH-1:0] sel_duration(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] e,
    input logic [WIDTH-1:0] y
  );
    case (sel)
      2'b01:   return e;
      2'b10:   return y;
      default: return b;
    endcase
  endfunction

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      count   <= '0;
      busy    <= 1'b0;
      expired <= 1'b0;
      base    <= WIDTH'(DEF_BASE);
      ext     <= WIDTH'(DEF_EXT);
      yel     <= WIDTH'(DEF_YEL);
    end else if (Prog_Sync) begin
      // Programming always aborts the countdown, so a new value only takes
      // effect from the next start_timer.
      case (Time_Parameter_Selector)
        2'b00: if (Time_Value != '0) base <= Time_Value;
        2'b01: if (Time_Value != '0) ext  <= Time_Value;
        2'b10: if (Time_Value != '0) yel  <= Time_Value;
        default: begin
          base <= WIDTH'(DEF_BASE);
          ext  <= WIDTH'(DEF_EXT);
          yel  <= WIDTH'(DEF_YEL);
        end
      endcase
      state   <= IDLE;
      count   <= '0;
      busy    <= 1'b0;
      expired <= 1'b0;
    end else if (start_timer) begin
      // Same load from IDLE, RUN (restart) and DONE (back-to-back).
      state   <= RUN;
      count   <= sel_duration(interval, base, ext, yel);
      busy    <= 1'b1;
      expired <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (one_hz_enable) begin
            if (count > WIDTH'(1)) begin
              count <= count - WIDTH'(1);
            end else begin
              count   <= '0;
              state   <= DONE;
              busy    <= 1'b0;
              expired <= 1'b1;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          expired <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          expired <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_interval_timer.sv
// Bench for traffic_interval_timer: vector table, directed corner sequences and
// randomized traffic, all checked against an arithmetic reference model.
module tb_traffic_interval_timer;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       one_hz_enable;
  logic       start_timer;
  logic [1:0] interval;
  logic       Prog_Sync;
  logic [1:0] Time_Parameter_Selector;
  logic [3:0] Time_Value;
  logic       expired;
  logic       busy;
  logic [3:0] count;

  traffic_interval_timer #(.WIDTH(4), .DEF_BASE(6), .DEF_EXT(3), .DEF_YEL(2)) dut (
    .clk(clk),
    .Reset_n(Reset_n),
    .one_hz_enable(one_hz_enable),
    .start_timer(start_timer),
    .interval(interval),
    .Prog_Sync(Prog_Sync),
    .Time_Parameter_Selector(Time_Parameter_Selector),
    .Time_Value(Time_Value),
    .expired(expired),
    .busy(busy),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: remaining seconds as an integer plus the stored durations.
  int m_par[3];
  int m_remaining;
  bit m_running;
  bit m_fired;

  function automatic int dur_index(input logic [1:0] iv);
    return (iv == 2'b01) ? 1 : (iv == 2'b10) ? 2 : 0;
  endfunction

  task automatic model_reset();
    m_par[0] = 6; m_par[1] = 3; m_par[2] = 2;
    m_remaining = 0; m_running = 0; m_fired = 0;
  endtask

  task automatic model_edge(input bit p, input logic [1:0] s, input logic [3:0] tv,
                            input bit st, input logic [1:0] iv, input bit tk);
    m_fired = 0;
    if (p) begin
      if (s == 2'b11) begin
        m_par[0] = 6; m_par[1] = 3; m_par[2] = 2;
      end else if (tv != 0) begin
        m_par[s] = int'(tv);
      end
      m_remaining = 0;
      m_running   = 0;
    end else if (st) begin
      m_remaining = m_par[dur_index(iv)];
      m_running   = 1;
    end else if (m_running && tk) begin
      m_remaining = m_remaining - 1;
      if (m_remaining <= 0) begin
        m_remaining = 0;
        m_running   = 0;
        m_fired     = 1;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".count"},   int'(count),   m_remaining);
    chk({tag, ".busy"},    int'(busy),    int'(m_running));
    chk({tag, ".expired"}, int'(expired), int'(m_fired));
  endtask

  // One clock: drive at the falling edge, let the rising edge sample, check 1 ns later.
  task automatic step(input bit p, input logic [1:0] s, input logic [3:0] tv,
                      input bit st, input logic [1:0] iv, input bit tk, input string tag);
    Prog_Sync = p; Time_Parameter_Selector = s; Time_Value = tv;
    start_timer = st; interval = iv; one_hz_enable = tk;
    @(posedge clk);
    model_edge(p, s, tv, st, iv, tk);
    #1;
    chk_model(tag);
    @(negedge clk);
  endtask

  task automatic idle(input bit tk, input string tag);
    step(0, 2'b00, 4'd0, 0, 2'b00, tk, tag);
  endtask

  typedef struct {
    bit       p;
    bit [1:0] s;
    bit [3:0] tv;
    bit       st;
    bit [1:0] iv;
    bit       tk;
    int       e_count;
    bit       e_busy;
    bit       e_exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit p, input bit [1:0] s, input bit [3:0] tv, input bit st,
                     input bit [1:0] iv, input bit tk, input int ec, input bit eb, input bit ee);
    vec_t v;
    v.p = p; v.s = s; v.tv = tv; v.st = st; v.iv = iv; v.tk = tk;
    v.e_count = ec; v.e_busy = eb; v.e_exp = ee;
    tbl.push_back(v);
  endtask

  // Start with the given interval, tick every 10 clocks, expect expiry after n ticks.
  task automatic run_interval(input logic [1:0] iv, input int n, input string tag);
    int  ticks = 0;
    bit  seen  = 0;
    step(0, 2'b00, 4'd0, 1, iv, 0, {tag, ".load"});
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      bit tk;
      tk = (cyc % 10 == 9);
      idle(tk, tag);
      if (tk) ticks++;
      if (expired) begin
        seen = 1;
        chk({tag, ".ticks"}, ticks, n);
        chk({tag, ".busy_drop"}, int'(busy), 0);
      end
    end
    if (!seen) chk({tag, ".timeout"}, 0, 1);
    idle(0, {tag, ".after"});
    chk({tag, ".pulse_width"}, int'(expired), 0);
  endtask

  initial begin
    Reset_n = 1'b0; Prog_Sync = 0; Time_Parameter_Selector = 0; Time_Value = 0;
    start_timer = 0; interval = 0; one_hz_enable = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset.count", int'(count), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.expired", int'(expired), 0);
    Reset_n = 1'b1;
    @(negedge clk);

    // Vector table: {prog, sel, value, start, interval, tick} -> {count, busy, expired}
    add(0, 2'b00, 0, 1, 2'b00, 0, 6, 1, 0);
    add(0, 2'b00, 0, 0, 2'b00, 1, 5, 1, 0);
    add(0, 2'b00, 0, 1, 2'b01, 1, 3, 1, 0);
    add(0, 2'b00, 0, 0, 2'b00, 1, 2, 1, 0);
    add(0, 2'b00, 0, 0, 2'b00, 1, 1, 1, 0);
    add(0, 2'b00, 0, 1, 2'b10, 1, 2, 1, 0);
    add(0, 2'b00, 0, 0, 2'b00, 1, 1, 1, 0);
    add(0, 2'b00, 0, 0, 2'b00, 1, 0, 0, 1);
    add(0, 2'b00, 0, 1, 2'b11, 0, 6, 1, 0);
    add(1, 2'b10, 5, 1, 2'b10, 0, 0, 0, 0);
    add(0, 2'b00, 0, 1, 2'b10, 1, 5, 1, 0);
    add(1, 2'b10, 0, 0, 2'b00, 0, 0, 0, 0);
    add(0, 2'b00, 0, 1, 2'b10, 0, 5, 1, 0);
    add(1, 2'b11, 9, 0, 2'b00, 0, 0, 0, 0);
    add(0, 2'b00, 0, 1, 2'b10, 0, 2, 1, 0);
    add(0, 2'b00, 0, 0, 2'b00, 1, 1, 1, 0);
    add(0, 2'b00, 0, 0, 2'b00, 0, 1, 1, 0);
    add(0, 2'b00, 0, 0, 2'b00, 1, 0, 0, 1);
    add(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
    add(0, 2'b00, 0, 0, 2'b00, 1, 0, 0, 0);
    add(1, 2'b00, 15, 0, 2'b00, 0, 0, 0, 0);
    add(0, 2'b00, 0, 1, 2'b11, 0, 15, 1, 0);
    add(1, 2'b11, 0, 0, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].p, tbl[i].s, tbl[i].tv, tbl[i].st, tbl[i].iv, tbl[i].tk, $sformatf("vec%0d", i));
      chk($sformatf("tbl%0d.count", i), int'(count), tbl[i].e_count);
      chk($sformatf("tbl%0d.busy", i), int'(busy), int'(tbl[i].e_busy));
      chk($sformatf("tbl%0d.expired", i), int'(expired), int'(tbl[i].e_exp));
    end

    // Interval decode with slow ticks
    run_interval(2'b00, 6, "int00");
    run_interval(2'b01, 3, "int01");
    run_interval(2'b10, 2, "int10");
    run_interval(2'b11, 6, "int11");
    step(1, 2'b10, 4'd5, 0, 2'b00, 0, "prog_yel5");
    run_interval(2'b10, 5, "yel5");
    step(1, 2'b10, 4'd0, 0, 2'b00, 0, "prog_yel0");
    run_interval(2'b10, 5, "yel_keep");
    step(1, 2'b11, 4'd0, 0, 2'b00, 0, "prog_defaults");
    run_interval(2'b10, 2, "yel_default");

    // Abort at count 3, then no expiry may ever follow
    begin
      int exp_seen = 0;
      step(0, 2'b00, 4'd0, 1, 2'b00, 0, "abort.load");
      repeat (3) idle(1, "abort.tick");
      chk("abort.pre_count", int'(count), 3);
      step(1, 2'b00, 4'd0, 0, 2'b00, 0, "abort.prog");
      chk("abort.count", int'(count), 0);
      chk("abort.busy", int'(busy), 0);
      for (int i = 0; i < 60; i++) begin
        idle(i % 3 == 0, "abort.wait");
        if (expired) exp_seen++;
      end
      chk("abort.no_expired", exp_seen, 0);
    end

    // Back-to-back: restart yellow in the expired cycle
    step(0, 2'b00, 4'd0, 1, 2'b01, 0, "b2b.load");
    repeat (2) idle(1, "b2b.tick");
    idle(1, "b2b.last");
    chk("b2b.expired", int'(expired), 1);
    step(0, 2'b00, 4'd0, 1, 2'b10, 0, "b2b.reload");
    chk("b2b.busy", int'(busy), 1);
    chk("b2b.count", int'(count), 2);

    // Asynchronous reset mid-run
    step(0, 2'b00, 4'd0, 1, 2'b00, 0, "arst.load");
    idle(1, "arst.tick");
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst.count", int'(count), 0);
    chk("arst.busy", int'(busy), 0);
    chk("arst.expired", int'(expired), 0);
    @(negedge clk);
    Reset_n = 1'b1;
    idle(1, "arst.after");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit p, st, tk;
      p  = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 7) == 0);
      tk = ($urandom_range(0, 2) == 0);
      step(p, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), st,
           2'($urandom_range(0, 3)), tk, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_interval_timer.md
# traffic_interval_timer

Programmable interval timer and time-parameter store that sequences the traffic-light FSM. It holds the base, extended and yellow durations in seconds and reloads a countdown whenever the FSM raises `start_timer`, using the FSM's `interval` code to pick the duration. It counts 1 Hz enable pulses from the clock divider and returns a one-cycle `expired` pulse to the FSM. Operator programming arrives pre-synchronised on `Prog_Sync`.

## Interface
- `WIDTH`, 4, width of each stored duration and of the countdown (seconds)
- `DEF_BASE`, 6, reset/default base duration (s)
- `DEF_EXT`, 3, reset/default extended duration (s)
- `DEF_YEL`, 2, reset/default yellow duration (s)

- `clk` in 1: single system clock; all state updates on its rising edge
- `Reset_n` in 1: asynchronous, active-low reset
- `one_hz_enable` in 1: one-`clk`-wide tick from the divider, once per second
- `start_timer` in 1: FSM request to (re)load and start the countdown
- `interval` in 2: duration select sampled with `start_timer`
  - 00: base
  - 01: extended
  - 10: yellow
  - 11: base
- `Prog_Sync` in 1: synchronised program strobe
- `Time_Parameter_Selector` in 2: register to program
  - 00: base
  - 01: extended
  - 10: yellow
  - 11: restore all defaults
- `Time_Value` in WIDTH: value written on `Prog_Sync`
- `expired` out 1: one-cycle pulse when the countdown reaches 0
- `busy` out 1: high while counting
- `count` out WIDTH: seconds remaining; 0 when not counting

## Operation
- Storage: three WIDTH-bit registers, `base`, `ext` and `yel`.
  - Reset values are `DEF_BASE`, `DEF_EXT` and `DEF_YEL`.
  - Defaults must be nonzero; a parameter of 0 is illegal.
- Priority at each edge: `Prog_Sync` > `start_timer` > `one_hz_enable`.
- Programming: with `Prog_Sync`=1, selector 00/01/10 writes `Time_Value` into the selected register.
  - If `Time_Value`=0, the write is ignored and the register keeps its old value.
  - Selector 11 reloads all three defaults.
  - Every `Prog_Sync` cycle also aborts any countdown: go to IDLE with `count`=0 and no `expired`.
- State machine, IDLE / RUN / DONE:
  - IDLE: `start_timer`=1 loads `count` from the register selected by `interval` and goes to RUN.
  - RUN, `start_timer`=1: reload `count` from the current `interval` and stay in RUN. This is a restart; no `expired` is generated.
  - RUN, `one_hz_enable`=1 with `count`>1: decrement `count`.
  - RUN, `one_hz_enable`=1 with `count`=1: set `count`=0 and go to DONE.
  - DONE: `expired`=1 for this single cycle. Next state is IDLE, or RUN if `start_timer`=1 in this cycle (a reload, as from IDLE).
- `one_hz_enable` has no effect in IDLE or DONE.
- `busy` = (state == RUN). `expired` = (state == DONE); both are registered.
- Arithmetic: unsigned WIDTH-bit arithmetic. `count` never decrements below 0 and never wraps.
- A parameter write during RUN has no effect on the current count, because `Prog_Sync` aborts the run anyway. The new value applies from the next `start_timer`.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, `count`=0, `busy`=0, `expired`=0, registers at defaults.
- Load latency: `start_timer` sampled at edge k gives `busy`=1 and `count`=N after edge k.
- A `one_hz_enable` pulse in the same cycle as `start_timer` is not counted.
- Expiry: after the N-th counted tick is sampled at edge m, `expired`=1 in the cycle after edge m only.
- Total time from start to `expired` is N one-second ticks; cycle-exact latency depends only on tick positions.
- Reset asserted mid-countdown clears everything immediately; no `expired` is generated.
- The FSM may assert `start_timer` in the same cycle it sees `expired`. That edge loads the new interval with no lost cycle.

## Test plan
- Reset defaults:
  - Stimulus: release reset, then `start_timer` with `interval`=00, ticks every 10 `clk`.
  - Required: `count` goes 6, 5, 4, 3, 2, 1, 0; `expired` high for exactly 1 cycle after the 6th tick; `busy` drops on the same edge.
- Interval decode: repeat with `interval`=01, 10 and 11.
  - Required: `expired` after 3, 2 and 6 ticks respectively.
- Programming:
  - `Prog_Sync` with selector 10 and `Time_Value`=5, then yellow start: `expired` after 5 ticks.
  - `Time_Value`=0: register unchanged, still 5.
  - Selector 11: yellow back to 2.
- Abort:
  - Stimulus: `Prog_Sync` pulse during RUN at `count`=3.
  - Required: `count`=0 and `busy`=0 next cycle; no `expired` ever follows.
- Simultaneous events:
  - `start_timer` with the final tick (`count`=1): reload to N, no `expired`.
  - `start_timer` with `one_hz_enable` from IDLE: `count`=N, not N-1.
  - `Prog_Sync` with `start_timer`: programming wins and the timer stays IDLE.
- Back-to-back:
  - Stimulus: `start_timer` in the `expired` cycle, with `interval`=10.
  - Required: `busy`=1 and `count`=2 next cycle.
  - Also assert `Reset_n` low mid-run: all outputs 0 within the same cycle.
